per2apb_bridge: RTL and testbench

Peripheral-interconnect target to APB master bridge. It accepts one request at a time on the peripheral-interconnect slave port and runs it as an APB3/APB4 SETUP/ACCESS transfer. It returns read data or an error on the interconnect response channel. It sits between the cluster/SoC peripheral interconnect and a downstream APB subsystem, so it is the counterpart of the APB-to-peripheral adapter.

---
 rtl/per2apb_bridge.sv | 132 +++++++++++++
 tb/tb_per2apb_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/per2apb_bridge.sv
// rtl/per2apb_bridge.sv - peripheral-interconnect target to APB3/APB4 master bridge.
// One outstanding request; every transfer, read or write, gets a single-cycle response.
module per2apb_bridge #(
  parameter int PER_ADDR_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int ID_WIDTH       = 5,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      per_slave_req_i,
  input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
  input  logic                      per_slave_we_i,
  input  logic [31:0]               per_slave_wdata_i,
  input  logic [3:0]                per_slave_be_i,
  input  logic [ID_WIDTH-1:0]       per_slave_id_i,
  output logic                      per_slave_gnt_o,
  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [31:0]               per_slave_r_rdata_o,
  output logic [ID_WIDTH-1:0]       per_slave_r_id_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic [3:0]                PSTRB,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_cnt;
  logic                 r_opc;
  logic [31:0]          r_rdata;
  logic [ID_WIDTH-1:0]  r_id;
  logic                 w_accept;
  logic                 w_timeout;

  // Grant is masked while reset is held so a request seen during reset is never accepted.
  assign w_accept  = (r_state == S_IDLE) && per_slave_req_i && !rst_i;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

  assign per_slave_gnt_o     = w_accept;
  assign per_slave_r_opc_o   = r_opc;
  assign per_slave_r_rdata_o = r_rdata;
  assign per_slave_r_id_o    = r_id;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next              = r_state;
    PSEL                = 1'b0;
    PENABLE             = 1'b0;
    per_slave_r_valid_o = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_SETUP;
      end
      S_SETUP: begin
        PSEL   = 1'b1;
        w_next = S_ACCESS;
      end
      S_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        per_slave_r_valid_o = 1'b1;
        w_next              = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      PADDR   <= '0;
      PWDATA  <= '0;
      PWRITE  <= 1'b0;
      PSTRB   <= 4'h0;
      r_id    <= '0;
      r_opc   <= 1'b0;
      r_rdata <= 32'h0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        PADDR  <= per_slave_add_i[APB_ADDR_WIDTH-1:0];
        PWDATA <= per_slave_wdata_i;
        PWRITE <= per_slave_we_i;
        PSTRB  <= per_slave_we_i ? per_slave_be_i : 4'h0;
        r_id   <= per_slave_id_i;
      end
      if (r_state == S_SETUP) begin
        r_cnt <= '0;
      end
      // PREADY wins over a timeout that would fire in the same cycle.
      if (r_state == S_ACCESS) begin
        if (PREADY) begin
          r_opc   <= PSLVERR;
          r_rdata <= PWRITE ? 32'h0 : PRDATA;
        end else if (w_timeout) begin
          r_opc   <= 1'b1;
          r_rdata <= 32'hDEAD_BEEF;
        end else if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_per2apb_bridge.sv
// tb/tb_per2apb_bridge.sv - directed vector bench for per2apb_bridge.
// Per-cycle vector table plus hand sequences for timeout, back-to-back and reset.
module tb_per2apb_bridge;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] add;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [4:0]  id;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic        e_gnt;
    logic        e_psel;
    logic        e_pen;
    logic        e_rv;
    logic        e_opc;
    logic [31:0] e_rdata;
    logic [4:0]  e_rid;
    logic [31:0] e_paddr;
    logic [31:0] e_pwdata;
    logic        e_pwrite;
    logic [3:0]  e_pstrb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] add;
  logic        we;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [4:0]  id;
  logic        gnt;
  logic        rv;
  logic        ropc;
  logic [31:0] rdata;
  logic [4:0]  rid;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic [3:0]  pstrb;
  logic        psel;
  logic        pen;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int total = 0;
  int bad   = 0;

  per2apb_bridge #(
    .PER_ADDR_WIDTH(32),
    .APB_ADDR_WIDTH(32),
    .ID_WIDTH(5),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .per_slave_req_i(req),
    .per_slave_add_i(add),
    .per_slave_we_i(we),
    .per_slave_wdata_i(wdata),
    .per_slave_be_i(be),
    .per_slave_id_i(id),
    .per_slave_gnt_o(gnt),
    .per_slave_r_valid_o(rv),
    .per_slave_r_opc_o(ropc),
    .per_slave_r_rdata_o(rdata),
    .per_slave_r_id_o(rid),
    .PADDR(paddr),
    .PWDATA(pwdata),
    .PWRITE(pwrite),
    .PSTRB(pstrb),
    .PSEL(psel),
    .PENABLE(pen),
    .PRDATA(prdata),
    .PREADY(pready),
    .PSLVERR(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_in();
    req = 1'b0; we = 1'b0; add = 32'h0; wdata = 32'h0; be = 4'h0; id = 5'd0;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
  endtask

  vec_t vecs[$];

  initial begin
    clr_in();
    rst = 1'b1;
    req = 1'b1;
    pready = 1'b1;
    #3;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_psel", 32'(psel), 32'h0);
    chk("rst_penable", 32'(pen), 32'h0);
    chk("rst_rvalid", 32'(rv), 32'h0);
    chk("rst_ropc", 32'(ropc), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rid", 32'(rid), 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_pwrite", 32'(pwrite), 32'h0);
    chk("rst_pstrb", 32'(pstrb), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    clr_in();

    // write, zero wait
    vecs.push_back('{1, 1, 32'h1A10_2004, 32'hCAFE_0001, 4'hF, 3, 1, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 4'h0});
    vecs.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 32'h0,                         0, 1, 0, 0, 0, 32'h0, 0, 32'h1A10_2004, 32'hCAFE_0001, 1, 4'hF});
    vecs.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 32'h9999_9999,                 0, 1, 1, 0, 0, 32'h0, 0, 32'h1A10_2004, 32'hCAFE_0001, 1, 4'hF});
    vecs.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 32'h0,                         0, 0, 0, 1, 0, 32'h0, 3, 32'h0, 32'h0, 0, 4'h0});
    // read, 3 wait states, PSLVERR without PREADY in one of them
    vecs.push_back('{1, 0, 32'h1A10_3000, 32'h7777_7777, 4'hF, 7, 0, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 4'h0});
    vecs.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0,                         0, 1, 0, 0, 0, 32'h0, 0, 32'h1A10_3000, 32'h7777_7777, 0, 4'h0});
    vecs.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0,                         0, 1, 1, 0, 0, 32'h0, 0, 32'h1A10_3000, 32'h7777_7777, 0, 4'h0});
    vecs.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 1, 32'h0,                         0, 1, 1, 0, 0, 32'h0, 0, 32'h1A10_3000, 32'h7777_7777, 0, 4'h0});
    vecs.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0,                         0, 1, 1, 0, 0, 32'h0, 0, 32'h1A10_3000, 32'h7777_7777, 0, 4'h0});
    vecs.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 32'h1234_5678,                 0, 1, 1, 0, 0, 32'h0, 0, 32'h1A10_3000, 32'h7777_7777, 0, 4'h0});
    vecs.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0,                         0, 0, 0, 1, 0, 32'h1234_5678, 7, 32'h0, 32'h0, 0, 4'h0});
    // read with slave error
    vecs.push_back('{1, 0, 32'h1A10_0010, 32'h0, 4'hA, 12, 0, 0, 32'h0,                1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 4'h0});
    vecs.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0,                         0, 1, 0, 0, 0, 32'h0, 0, 32'h1A10_0010, 32'h0, 0, 4'h0});
    vecs.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 1, 32'hAAAA_5555,                 0, 1, 1, 0, 0, 32'h0, 0, 32'h1A10_0010, 32'h0, 0, 4'h0});
    vecs.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0,                         0, 0, 0, 1, 1, 32'hAAAA_5555, 12, 32'h0, 32'h0, 0, 4'h0});
    // write with slave error after one wait, partial strobes
    vecs.push_back('{1, 1, 32'h0000_0F0C, 32'h0BAD_F00D, 4'h3, 31, 0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 4'h0});
    vecs.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0,                         0, 1, 0, 0, 0, 32'h0, 0, 32'h0000_0F0C, 32'h0BAD_F00D, 1, 4'h3});
    vecs.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0,                         0, 1, 1, 0, 0, 32'h0, 0, 32'h0000_0F0C, 32'h0BAD_F00D, 1, 4'h3});
    vecs.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 1, 32'hFFFF_FFFF,                 0, 1, 1, 0, 0, 32'h0, 0, 32'h0000_0F0C, 32'h0BAD_F00D, 1, 4'h3});
    vecs.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0,                         0, 0, 0, 1, 1, 32'h0, 31, 32'h0, 32'h0, 0, 4'h0});

    foreach (vecs[i]) begin
      req = vecs[i].req; we = vecs[i].we; add = vecs[i].add; wdata = vecs[i].wdata;
      be = vecs[i].be; id = vecs[i].id; pready = vecs[i].pready;
      pslverr = vecs[i].pslverr; prdata = vecs[i].prdata;
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
      chk($sformatf("v%0d_psel", i), 32'(psel), 32'(vecs[i].e_psel));
      chk($sformatf("v%0d_penable", i), 32'(pen), 32'(vecs[i].e_pen));
      chk($sformatf("v%0d_rvalid", i), 32'(rv), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) begin
        chk($sformatf("v%0d_ropc", i), 32'(ropc), 32'(vecs[i].e_opc));
        chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
        chk($sformatf("v%0d_rid", i), 32'(rid), 32'(vecs[i].e_rid));
      end
      if (vecs[i].e_psel) begin
        chk($sformatf("v%0d_paddr", i), paddr, vecs[i].e_paddr);
        chk($sformatf("v%0d_pwdata", i), pwdata, vecs[i].e_pwdata);
        chk($sformatf("v%0d_pwrite", i), 32'(pwrite), 32'(vecs[i].e_pwrite));
        chk($sformatf("v%0d_pstrb", i), 32'(pstrb), 32'(vecs[i].e_pstrb));
      end
      tick();
    end
    clr_in();

    // timeout: response in cycle 6
    req = 1'b1; add = 32'h1A10_4000; id = 5'd9;
    #1;
    chk("to_gnt", 32'(gnt), 32'h1);
    tick();
    clr_in();
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (c < 6) begin
        chk($sformatf("to_c%0d_rvalid", c), 32'(rv), 32'h0);
        chk($sformatf("to_c%0d_psel", c), 32'(psel), 32'h1);
      end else begin
        chk("to_rvalid", 32'(rv), 32'h1);
        chk("to_ropc", 32'(ropc), 32'h1);
        chk("to_rdata", rdata, 32'hDEAD_BEEF);
        chk("to_rid", 32'(rid), 32'd9);
        chk("to_psel", 32'(psel), 32'h0);
      end
      tick();
    end

    // PREADY in the cycle the timeout would fire
    req = 1'b1; add = 32'h1A10_4004; id = 5'd10;
    #1;
    chk("tob_gnt", 32'(gnt), 32'h1);
    tick();
    clr_in();
    for (int c = 1; c <= 6; c++) begin
      pready = (c == 5);
      prdata = 32'h0000_0055;
      #1;
      if (c < 6) begin
        chk($sformatf("tob_c%0d_rvalid", c), 32'(rv), 32'h0);
      end else begin
        chk("tob_rvalid", 32'(rv), 32'h1);
        chk("tob_ropc", 32'(ropc), 32'h0);
        chk("tob_rdata", rdata, 32'h0000_0055);
      end
      tick();
    end
    clr_in();

    // back-to-back with request held high
    pready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req = (c <= 8); we = 1'b1; be = 4'hF;
      add = 32'h100 + 32'(c); wdata = 32'(c); id = 5'(c / 4 + 1);
      #1;
      chk($sformatf("b2b_c%0d_gnt", c), 32'(gnt), 32'((c % 4 == 0) && (c <= 8)));
      if (c % 4 == 3) begin
        chk($sformatf("b2b_c%0d_rvalid", c), 32'(rv), 32'h1);
        chk($sformatf("b2b_c%0d_rid", c), 32'(rid), 32'(c / 4 + 1));
      end
      tick();
    end
    clr_in();

    // reset during a wait state
    req = 1'b1; add = 32'h1A10_5000; id = 5'd21;
    #1;
    chk("rm_gnt", 32'(gnt), 32'h1);
    tick();
    clr_in();
    tick();
    tick();
    #1;
    chk("rm_penable_pre", 32'(pen), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rm_psel", 32'(psel), 32'h0);
    chk("rm_penable", 32'(pen), 32'h0);
    chk("rm_rvalid", 32'(rv), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      pready = 1'b1;
      #1;
      chk($sformatf("rm_post_c%0d_rvalid", c), 32'(rv), 32'h0);
      tick();
    end
    req = 1'b1; we = 1'b1; add = 32'h1A10_6000; wdata = 32'h1; be = 4'h1; id = 5'd22;
    #1;
    chk("rm_next_gnt", 32'(gnt), 32'h1);
    tick();
    req = 1'b0;
    tick();
    tick();
    #1;
    chk("rm_next_rvalid", 32'(rv), 32'h1);
    chk("rm_next_rid", 32'(rid), 32'd22);
    chk("rm_next_ropc", 32'(ropc), 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
